// File: rtl/icache_pkg.sv
// Shared parameters and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

   localparam int unsigned ICACHE_LINES = 64;
   localparam int unsigned ADDR_W       = 32;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned IDX_W        = $clog2(ICACHE_LINES);
   localparam int unsigned IDX_LSB      = 2;
   localparam int unsigned TAG_LSB      = IDX_LSB + IDX_W;
   localparam int unsigned TAG_W        = ADDR_W - TAG_LSB;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one combinational read port, one write port, sync clear of valid bits.
module icache_array
   import icache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid_c,
   output logic [TAG_W-1:0]  rd_tag_c,
   output logic [DATA_W-1:0] rd_data_c,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data
);

   logic [ICACHE_LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]        tag_q  [ICACHE_LINES];
   logic [TAG_W-1:0]        tag_d  [ICACHE_LINES];
   logic [DATA_W-1:0]       data_q [ICACHE_LINES];
   logic [DATA_W-1:0]       data_d [ICACHE_LINES];

   // Read port
   always_comb begin
      rd_valid_c = valid_q[rd_idx];
      rd_tag_c   = tag_q[rd_idx];
      rd_data_c  = data_q[rd_idx];
   end

   // Line write, only while the pipeline is not frozen
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (en && wr_en) begin
         valid_d[wr_idx] = 1'b1;
         tag_d[wr_idx]   = wr_tag;
         data_d[wr_idx]  = wr_data;
      end
   end

   // Storage registers; reset invalidates every line and blocks any pending write
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache, one word per line, single outstanding refill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
   import icache_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        fch_sgn_in,
   input  logic [31:0] fch_addr,
   input  logic        fch_clr,
   output logic        fch_sgn_out,
   output logic [31:0] fch_ins,
   output logic        mem_sgn_out,
   output logic [31:0] mem_addr,
   input  logic        mem_sgn_in,
   input  logic [31:0] mem_val
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   state_e              state_q, state_d;
   logic                fch_sgn_out_q, fch_sgn_out_d;
   logic [DATA_W-1:0]   fch_ins_q, fch_ins_d;
   logic                mem_sgn_out_q, mem_sgn_out_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                kill_q, kill_d;

   logic                rd_valid_c;
   logic [TAG_W-1:0]    rd_tag_c;
   logic [DATA_W-1:0]   rd_data_c;
   logic                hit_c;
   logic                accept_c;
   logic                refill_done_c;
   logic                kill_now_c;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^fch_addr[IDX_LSB-1:0];

   icache_array u_array (
      .clk        (clk),
      .rst        (rst),
      .en         (rdy),
      .rd_idx     (fch_addr[TAG_LSB-1:IDX_LSB]),
      .rd_valid_c (rd_valid_c),
      .rd_tag_c   (rd_tag_c),
      .rd_data_c  (rd_data_c),
      .wr_en      (refill_done_c),
      .wr_idx     (mem_addr_q[TAG_LSB-1:IDX_LSB]),
      .wr_tag     (mem_addr_q[ADDR_W-1:TAG_LSB]),
      .wr_data    (mem_val)
   );

   // Request qualification; the cycle of a response pulse never starts a new request
   always_comb begin
      hit_c         = rd_valid_c && (rd_tag_c == fch_addr[ADDR_W-1:TAG_LSB]);
      accept_c      = (state_q == ST_IDLE) && fch_sgn_in && !fch_sgn_out_q && !fch_clr;
      refill_done_c = (state_q == ST_REFILL) && mem_sgn_in;
      kill_now_c    = kill_q || fch_clr || !fch_sgn_in;
   end

   // Next state and registered outputs
   always_comb begin
      state_d       = state_q;
      fch_sgn_out_d = 1'b0;
      fch_ins_d     = fch_ins_q;
      mem_sgn_out_d = mem_sgn_out_q;
      mem_addr_d    = mem_addr_q;
      kill_d        = kill_q;
      unique case (state_q)
         ST_IDLE: begin
            kill_d = 1'b0;
            if (accept_c) begin
               if (hit_c) begin
                  fch_sgn_out_d = 1'b1;
                  fch_ins_d     = rd_data_c;
               end else begin
                  mem_sgn_out_d = 1'b1;
                  mem_addr_d    = {fch_addr[ADDR_W-1:IDX_LSB], 2'b00};
                  state_d       = ST_REFILL;
               end
            end
         end
         ST_REFILL: begin
            // The memory transfer cannot be cancelled; a flush only suppresses the response
            kill_d = kill_now_c;
            if (mem_sgn_in) begin
               mem_sgn_out_d = 1'b0;
               kill_d        = 1'b0;
               if (kill_now_c) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d       = ST_RESP;
                  fch_sgn_out_d = 1'b1;
                  fch_ins_d     = mem_val;
               end
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; rdy low freezes everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         fch_sgn_out_q <= 1'b0;
         fch_ins_q     <= '0;
         mem_sgn_out_q <= 1'b0;
         mem_addr_q    <= '0;
         kill_q        <= 1'b0;
      end else if (rdy) begin
         state_q       <= state_d;
         fch_sgn_out_q <= fch_sgn_out_d;
         fch_ins_q     <= fch_ins_d;
         mem_sgn_out_q <= mem_sgn_out_d;
         mem_addr_q    <= mem_addr_d;
         kill_q        <= kill_d;
      end
   end

   assign fch_sgn_out = fch_sgn_out_q;
   assign fch_ins     = fch_ins_q;
   assign mem_sgn_out = mem_sgn_out_q;
   assign mem_addr    = mem_addr_q;

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   // Served hits and refill starts, wrapping naturally
   always_comb begin
      hit_cnt_d  = hit_cnt_q + 32'(accept_c && hit_c);
      miss_cnt_d = miss_cnt_q + 32'(accept_c && !hit_c);
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (rdy) begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Testbench for icache: directed table, hand-written corner sequences, randomized fetches.
module tb_icache;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        fch_sgn_in;
   logic [31:0] fch_addr;
   logic        fch_clr;
   logic        fch_sgn_out;
   logic [31:0] fch_ins;
   logic        mem_sgn_out;
   logic [31:0] mem_addr;
   logic        mem_sgn_in;
   logic [31:0] mem_val;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   icache dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .fch_sgn_in  (fch_sgn_in),
      .fch_addr    (fch_addr),
      .fch_clr     (fch_clr),
      .fch_sgn_out (fch_sgn_out),
      .fch_ins     (fch_ins),
      .mem_sgn_out (mem_sgn_out),
      .mem_addr    (mem_addr),
      .mem_sgn_in  (mem_sgn_in),
      .mem_val     (mem_val)
`ifdef ICACHE_STATS_EN
      ,
      .hit_cnt     (hit_cnt),
      .miss_cnt    (miss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_hits = 0;
   int exp_misses = 0;

   // Reference model: word address -> cached word; lines sharing an index evict each other
   logic [31:0] contents [bit [29:0]];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
      int          clr_at;
      bit          drop;
      int          lat;
      bit          exp_hit;
      logic [31:0] exp_ins;
      bit          exp_resp;
   } vec_t;

   vec_t tbl [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_fill(input logic [31:0] addr, input logic [31:0] word);
      bit [29:0] wa;
      bit [29:0] victims [$];
      wa = addr[31:2];
      foreach (contents[k]) if ((k % 64) == (wa % 64)) victims.push_back(k);
      foreach (victims[i]) contents.delete(victims[i]);
      contents[wa] = word;
   endtask

   // Drive one fetch as IFetch plus memory controller and check the observable protocol
   task automatic run_fetch(input logic [31:0] addr, input logic [31:0] word, input int clr_at,
                            input bit drop, input int lat, input bit exp_hit,
                            input logic [31:0] exp_ins, input bit exp_resp);
      logic [31:0] aligned;
      aligned = {addr[31:2], 2'b00};
      fch_addr = addr;
      fch_sgn_in = 1'b1;
      fch_clr = 1'b0;
      tick();
      if (exp_hit) begin
         chk("hit_pulse", 32'(fch_sgn_out), 32'd1);
         chk("hit_ins", fch_ins, exp_ins);
         chk("hit_no_mem", 32'(mem_sgn_out), 32'd0);
         tick();
         chk("hit_single_pulse", 32'(fch_sgn_out), 32'd0);
      end else begin
         chk("miss_mem_req", 32'(mem_sgn_out), 32'd1);
         chk("miss_mem_addr", mem_addr, aligned);
         chk("miss_no_pulse", 32'(fch_sgn_out), 32'd0);
         for (int c = 0; c < lat; c++) begin
            if (c == clr_at) begin
               if (drop) fch_sgn_in = 1'b0;
               else fch_clr = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
               rdy = 1'b0;
            end
            tick();
            rdy = 1'b1;
            fch_clr = 1'b0;
            chk("refill_hold_req", 32'(mem_sgn_out), 32'd1);
            chk("refill_hold_addr", mem_addr, aligned);
            chk("refill_no_pulse", 32'(fch_sgn_out), 32'd0);
         end
         if (clr_at == lat) begin
            if (drop) fch_sgn_in = 1'b0;
            else fch_clr = 1'b1;
         end
         if (!exp_resp) fch_sgn_in = 1'b0;
         mem_sgn_in = 1'b1;
         mem_val = word;
         tick();
         mem_sgn_in = 1'b0;
         mem_val = 32'h0;
         fch_clr = 1'b0;
         chk("refill_req_drop", 32'(mem_sgn_out), 32'd0);
         if (exp_resp) begin
            chk("resp_pulse", 32'(fch_sgn_out), 32'd1);
            chk("resp_ins", fch_ins, exp_ins);
         end else begin
            chk("killed_no_pulse", 32'(fch_sgn_out), 32'd0);
         end
         tick();
         chk("resp_single_pulse", 32'(fch_sgn_out), 32'd0);
         chk("resp_no_mem", 32'(mem_sgn_out), 32'd0);
      end
      fch_sgn_in = 1'b0;
   endtask

   // Fetch whose expectations come from the reference model
   task automatic model_fetch(input logic [31:0] addr, input int clr_at, input bit drop, input int lat);
      bit [29:0]   wa;
      logic [31:0] word;
      bit          hit;
      wa = addr[31:2];
      word = $urandom;
      hit = contents.exists(wa);
      if (hit) begin
         run_fetch(addr, word, -1, 1'b0, 0, 1'b1, contents[wa], 1'b1);
         exp_hits++;
      end else begin
         run_fetch(addr, word, clr_at, drop, lat, 1'b0, word, clr_at < 0);
         model_fill(addr, word);
         exp_misses++;
      end
   endtask

   initial begin
      rst = 1'b1;
      rdy = 1'b1;
      fch_sgn_in = 1'b0;
      fch_addr = 32'h0;
      fch_clr = 1'b0;
      mem_sgn_in = 1'b0;
      mem_val = 32'h0;

      tbl[0] = '{32'h0000_0000, 32'h0000_0013, -1, 1'b0, 2, 1'b0, 32'h0000_0013, 1'b1};
      tbl[1] = '{32'h0000_0000, 32'h0,         -1, 1'b0, 0, 1'b1, 32'h0000_0013, 1'b1};
      tbl[2] = '{32'h0000_0100, 32'hDEAD_BEEF, -1, 1'b0, 1, 1'b0, 32'hDEAD_BEEF, 1'b1};
      tbl[3] = '{32'h0000_0000, 32'h0000_0013, -1, 1'b0, 0, 1'b0, 32'h0000_0013, 1'b1};
      tbl[4] = '{32'h0000_0004, 32'h1111_1111,  1, 1'b0, 4, 1'b0, 32'h0,         1'b0};
      tbl[5] = '{32'h0000_0006, 32'h0,         -1, 1'b0, 0, 1'b1, 32'h1111_1111, 1'b1};
      tbl[6] = '{32'h0000_0104, 32'h0000_0022,  0, 1'b1, 3, 1'b0, 32'h0,         1'b0};
      tbl[7] = '{32'h0000_0104, 32'h0,         -1, 1'b0, 0, 1'b1, 32'h0000_0022, 1'b1};
      tbl[8] = '{32'h0000_0008, 32'h0000_0033,  2, 1'b0, 2, 1'b0, 32'h0,         1'b0};
      tbl[9] = '{32'h0000_000B, 32'h0,         -1, 1'b0, 0, 1'b1, 32'h0000_0033, 1'b1};

      tick();
      tick();
      chk("rst_fch_sgn_out", 32'(fch_sgn_out), 32'd0);
      chk("rst_fch_ins", fch_ins, 32'h0);
      chk("rst_mem_sgn_out", 32'(mem_sgn_out), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      rst = 1'b0;
      tick();

      // Directed table: cold miss, refetch, conflict, flushes during refill
      for (int i = 0; i < 10; i++) begin
         run_fetch(tbl[i].addr, tbl[i].word, tbl[i].clr_at, tbl[i].drop, tbl[i].lat,
                   tbl[i].exp_hit, tbl[i].exp_ins, tbl[i].exp_resp);
         if (tbl[i].exp_hit) exp_hits++;
         else begin
            model_fill(tbl[i].addr, tbl[i].word);
            exp_misses++;
         end
      end

      // Randomized fetches over a small address pool to force hits and conflicts
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         int          lat;
         int          clr_at;
         a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
         lat = $urandom_range(0, 4);
         clr_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat) : -1;
         model_fetch(a, clr_at, $urandom_range(0, 1) == 1, lat);
         if ($urandom_range(0, 3) == 0) tick();
      end

      // Flush in IDLE suppresses both a hit response and a refill
      model_fetch(32'h0000_0300, -1, 1'b0, 1);
      fch_addr = 32'h0000_0300;
      fch_sgn_in = 1'b1;
      fch_clr = 1'b1;
      tick();
      chk("idle_clr_hit_no_pulse", 32'(fch_sgn_out), 32'd0);
      chk("idle_clr_hit_no_mem", 32'(mem_sgn_out), 32'd0);
      fch_addr = 32'hFFFF_FFFC;
      tick();
      chk("idle_clr_miss_no_mem", 32'(mem_sgn_out), 32'd0);
      chk("idle_clr_miss_no_pulse", 32'(fch_sgn_out), 32'd0);
      fch_clr = 1'b0;
      fch_sgn_in = 1'b0;
      tick();

      // rdy low while a hit pulse is up: the pulse holds, and is not repeated afterwards
      fch_addr = 32'h0000_0300;
      fch_sgn_in = 1'b1;
      tick();
      exp_hits++;
      chk("freeze_hit_pulse", 32'(fch_sgn_out), 32'd1);
      chk("freeze_hit_ins", fch_ins, contents[30'h0C0]);
      rdy = 1'b0;
      tick();
      tick();
      chk("freeze_pulse_held", 32'(fch_sgn_out), 32'd1);
      chk("freeze_ins_held", fch_ins, contents[30'h0C0]);
      rdy = 1'b1;
      tick();
      chk("freeze_single_pulse", 32'(fch_sgn_out), 32'd0);
      fch_sgn_in = 1'b0;
      tick();

      // Reset in the middle of a refill abandons it
      fch_addr = 32'hFFFF_FFF0;
      fch_sgn_in = 1'b1;
      tick();
      chk("rst_mid_req", 32'(mem_sgn_out), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      chk("rst_mid_mem_sgn_out", 32'(mem_sgn_out), 32'd0);
      chk("rst_mid_mem_addr", mem_addr, 32'h0);
      chk("rst_mid_fch_sgn_out", 32'(fch_sgn_out), 32'd0);
      chk("rst_mid_fch_ins", fch_ins, 32'h0);
      rst = 1'b0;
      fch_sgn_in = 1'b0;
      contents.delete();
      exp_hits = 0;
      exp_misses = 0;
      tick();
      model_fetch(32'h0000_0000, -1, 1'b0, 1);
      model_fetch(32'hFFFF_FFF0, -1, 1'b0, 0);

      // rdy low for 3 cycles mid-refill; a mem_sgn_in during the freeze is ignored
      fch_addr = 32'h0000_0040;
      fch_sgn_in = 1'b1;
      tick();
      exp_misses++;
      chk("stall_req", 32'(mem_sgn_out), 32'd1);
      chk("stall_addr", mem_addr, 32'h0000_0040);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mem_sgn_in = (i == 1);
         mem_val = 32'hBADB_AD00;
         tick();
         chk("stall_req_held", 32'(mem_sgn_out), 32'd1);
         chk("stall_addr_held", mem_addr, 32'h0000_0040);
         chk("stall_no_pulse", 32'(fch_sgn_out), 32'd0);
      end
      rdy = 1'b1;
      mem_sgn_in = 1'b0;
      tick();
      chk("stall_req_after", 32'(mem_sgn_out), 32'd1);
      mem_sgn_in = 1'b1;
      mem_val = 32'h0000_0013;
      tick();
      mem_sgn_in = 1'b0;
      chk("stall_resp_pulse", 32'(fch_sgn_out), 32'd1);
      chk("stall_resp_ins", fch_ins, 32'h0000_0013);
      chk("stall_req_drop", 32'(mem_sgn_out), 32'd0);
      tick();
      chk("stall_single_pulse", 32'(fch_sgn_out), 32'd0);
      fch_sgn_in = 1'b0;
      model_fill(32'h0000_0040, 32'h0000_0013);
      model_fetch(32'h0000_0040, -1, 1'b0, 0);

`ifdef ICACHE_STATS_EN
      chk("hit_cnt", hit_cnt, 32'(exp_hits));
      chk("miss_cnt", miss_cnt, 32'(exp_misses));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 rdy  input  1  global ready; low = all state frozen, outputs hold.
REQ-004 fch_sgn_in  input  1  fetch request from IFetch; held high until fch_sgn_out pulse.
REQ-005 fch_addr  input  32  fetch PC; bits [1:0] ignored.
REQ-006 fch_clr  input  1  flush (branch mispredict); kills outstanding response.
REQ-007 fch_sgn_out  output  1  one-cycle pulse: fch_ins valid.
REQ-008 fch_ins  output  32  fetched instruction word.
REQ-009 mem_sgn_out  output  1  refill request to memory controller; level, held until mem_sgn_in.
REQ-010 mem_addr  output  32  refill address, word aligned ({fch_addr[31:2],2'b00}).
REQ-011 mem_sgn_in  input  1  one-cycle pulse: mem_val valid, refill done.
REQ-012 mem_val  input  32  refill word, little-endian assembled.

Function
REQ-013 Direct-mapped, ICACHE_LINES=64 lines, one 32-bit word per line; index=addr[7:2], tag=addr[31:8], one valid bit per line.
REQ-014 FSM states IDLE, REFILL, RESP; IDLE after reset.
REQ-015 IDLE, fch_sgn_in=1, hit: fch_ins=line data, fch_sgn_out=1 on next cycle (latency 1), stay IDLE; no memory request.
REQ-016 IDLE, fch_sgn_in=1, miss: latch addr, go REFILL, mem_sgn_out=1 and mem_addr valid from next cycle.
REQ-017 REFILL: mem_sgn_out and mem_addr constant until mem_sgn_in; mem_sgn_out deasserted the cycle after mem_sgn_in.
REQ-018 On mem_sgn_in: write tag/data, set valid, go RESP; RESP drives fch_sgn_out=1, fch_ins=mem_val for exactly one cycle, then IDLE.
REQ-019 fch_sgn_out SHALL never be high two consecutive cycles for one request; IDLE ignores fch_sgn_in in cycle fch_sgn_out is high.
REQ-020 fch_clr in IDLE: no response this cycle, even on hit; stay IDLE.
REQ-021 fch_clr in REFILL: request not aborted (memory transfer cannot be cancelled); line still written; response suppressed (RESP skipped, direct to IDLE).
REQ-022 fch_clr and mem_sgn_in same cycle: line written, no response.
REQ-023 fch_sgn_in dropped during REFILL: treated as fch_clr.
REQ-024 rdy=0: FSM, arrays, outputs frozen; mem_sgn_in ignored (memory controller also frozen).

Reset
REQ-025 rst: all valid bits 0, state IDLE, fch_sgn_out=0, fch_ins=0, mem_sgn_out=0, mem_addr=0; reset mid-REFILL abandons refill, no array write.

Configuration
REQ-026 ICACHE_STATS_EN defined: adds outputs hit_cnt[31:0], miss_cnt[31:0]; +1 per served hit / per refill start; reset 0; wrap at 2^32.
REQ-027 ICACHE_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.

Structure
REQ-028 ICACHE_LINES, index/tag widths, FSM state encodings in shared defines.v.
REQ-029 Storage in sub-module icache_array (valid/tag/data, one read, one write port, sync clear); FSM in icache.

Verification
REQ-030 Cold fetch 0x00000000: mem_sgn_out next cycle, mem_addr=0; mem_sgn_in with 0x00000013 -> fch_sgn_out pulse 1 cycle later, fch_ins=0x00000013.
REQ-031 Refetch 0x00000000: fch_sgn_out next cycle, fch_ins=0x00000013, mem_sgn_out stays 0.
REQ-032 Conflict: fetch 0x00000100 (same index, tag 1) -> miss, refill 0xDEADBEEF; then 0x00000000 -> miss again.
REQ-033 fch_clr 2 cycles into REFILL of 0x00000004: mem_sgn_out held to mem_sgn_in, no fch_sgn_out; later fetch 0x00000004 hits.
REQ-034 rst asserted mid-REFILL: next cycle mem_sgn_out=0; fetch 0x00000000 misses.
REQ-035 rdy low 3 cycles during REFILL: mem_sgn_out, mem_addr unchanged; completion as REQ-030 after rdy returns.
